// File: rtl/inst_fetch_arb_pkg.sv
// Shared types for the instruction fetch arbiter: bus width, owner encoding,
// grant bit positions and the registered response record.
package inst_fetch_arb_pkg;

    localparam int InstBus = 32;

    typedef logic [InstBus-1:0] inst_t;

    localparam inst_t ZeroWord = '0;

    localparam int GntCpu = 0;
    localparam int GntDbg = 1;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } owner_e;

    typedef struct packed {
        logic  valid;
        logic  err;
        inst_t data;
    } rsp_t;

endpackage

// File: rtl/ifetch_arb_core.sv
// Grant decision for the fetch arbiter: two requests plus arbitration state in,
// one-hot grant out. IFETCH_RR_EN selects round-robin instead of CPU priority.
import inst_fetch_arb_pkg::*;

module ifetch_arb_core #(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 3
) (
    input  logic             cpu_req,
    input  logic             dbg_req,
`ifdef IFETCH_RR_EN
    input  owner_e           last_owner,
`else
    input  logic [CNT_W-1:0] starve_cnt,
`endif
    output logic [1:0]       gnt_oh
);

    logic dbg_wins;

    always_comb begin
        gnt_oh = 2'b00;
`ifdef IFETCH_RR_EN
        dbg_wins = dbg_req && (!cpu_req || (last_owner == OWN_CPU));
`else
        // Debug only beats a requesting CPU once it has waited out STARVE_MAX losses.
        dbg_wins = dbg_req && (!cpu_req || (starve_cnt == CNT_W'(STARVE_MAX)));
`endif
        if (dbg_wins) begin
            gnt_oh[GntDbg] = 1'b1;
        end else if (cpu_req) begin
            gnt_oh[GntCpu] = 1'b1;
        end
    end

endmodule

// File: rtl/inst_fetch_arb.sv
// Instruction fetch arbiter sharing one combinational ROM between CPU and debug.
// Build with IFETCH_RR_EN defined for round-robin instead of CPU priority.
import inst_fetch_arb_pkg::*;

module inst_fetch_arb #(
    parameter int ADDR_W     = 32,
    parameter int MEM_LOG2   = 17,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_gnt,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic              dbg_gnt,
    output logic              cpu_rvalid,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_rerr,
    output logic              dbg_rvalid,
    output logic [31:0]       dbg_rdata,
    output logic              dbg_rerr,
    input  logic              cpu_flush,
    output logic              rom_ce,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_inst
);

    logic [1:0]        gnt_oh;
    logic [1:0]        gnt;
    logic [ADDR_W-1:0] sel_addr;
    logic              addr_bad;
    inst_t             fetch_word;

    rsp_t  cpu_pend_q, cpu_pend_d;
    rsp_t  dbg_rsp_q,  dbg_rsp_d;
    inst_t cpu_data_q, cpu_data_d;

`ifdef IFETCH_RR_EN
    owner_e last_owner_q, last_owner_d;

    ifetch_arb_core #(
        .STARVE_MAX (STARVE_MAX),
        .CNT_W      (1)
    ) u_core (
        .cpu_req    (cpu_req),
        .dbg_req    (dbg_req),
        .last_owner (last_owner_q),
        .gnt_oh     (gnt_oh)
    );
`else
    localparam int CntW = $clog2(STARVE_MAX + 1);

    logic [CntW-1:0] starve_q, starve_d;

    ifetch_arb_core #(
        .STARVE_MAX (STARVE_MAX),
        .CNT_W      (CntW)
    ) u_core (
        .cpu_req    (cpu_req),
        .dbg_req    (dbg_req),
        .starve_cnt (starve_q),
        .gnt_oh     (gnt_oh)
    );
`endif

    // Grants are suppressed while reset is held so nothing is accepted mid-reset.
    assign gnt     = gnt_oh & {2{rst}};
    assign cpu_gnt = gnt[GntCpu];
    assign dbg_gnt = gnt[GntDbg];

    always_comb begin
        sel_addr = '0;
        if (gnt[GntDbg]) begin
            sel_addr = dbg_addr;
        end else if (gnt[GntCpu]) begin
            sel_addr = cpu_addr;
        end
        addr_bad   = (sel_addr[1:0] != 2'b00) || ((sel_addr >> (MEM_LOG2 + 2)) != '0);
        fetch_word = addr_bad ? ZeroWord : rom_inst;
        rom_ce     = (gnt != 2'b00) && !addr_bad;
        rom_addr   = sel_addr;
    end

    // Pending CPU response is separate from the committed word so a flush can
    // hide a response without disturbing what cpu_rdata already shows.
    always_comb begin
        cpu_pend_d.valid = gnt[GntCpu];
        cpu_pend_d.err   = gnt[GntCpu] && addr_bad;
        cpu_pend_d.data  = gnt[GntCpu] ? fetch_word : cpu_pend_q.data;

        cpu_data_d = cpu_data_q;
        if (cpu_pend_q.valid && !cpu_flush) begin
            cpu_data_d = cpu_pend_q.data;
        end

        dbg_rsp_d.valid = gnt[GntDbg];
        dbg_rsp_d.err   = gnt[GntDbg] && addr_bad;
        dbg_rsp_d.data  = gnt[GntDbg] ? fetch_word : dbg_rsp_q.data;
    end

`ifdef IFETCH_RR_EN
    always_comb begin
        last_owner_d = last_owner_q;
        if (gnt[GntDbg]) begin
            last_owner_d = OWN_DBG;
        end else if (gnt[GntCpu]) begin
            last_owner_d = OWN_CPU;
        end
    end
`else
    always_comb begin
        starve_d = starve_q;
        if (!dbg_req || gnt[GntDbg]) begin
            starve_d = '0;
        end else if (starve_q != CntW'(STARVE_MAX)) begin
            starve_d = starve_q + CntW'(1);
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpu_pend_q <= '0;
            dbg_rsp_q  <= '0;
            cpu_data_q <= ZeroWord;
`ifdef IFETCH_RR_EN
            last_owner_q <= OWN_CPU;
`else
            starve_q <= '0;
`endif
        end else begin
            cpu_pend_q <= cpu_pend_d;
            dbg_rsp_q  <= dbg_rsp_d;
            cpu_data_q <= cpu_data_d;
`ifdef IFETCH_RR_EN
            last_owner_q <= last_owner_d;
`else
            starve_q <= starve_d;
`endif
        end
    end

    assign cpu_rvalid = cpu_pend_q.valid && !cpu_flush;
    assign cpu_rerr   = cpu_pend_q.err && !cpu_flush;
    assign cpu_rdata  = cpu_rvalid ? cpu_pend_q.data : cpu_data_q;

    assign dbg_rvalid = dbg_rsp_q.valid;
    assign dbg_rerr   = dbg_rsp_q.err;
    assign dbg_rdata  = dbg_rsp_q.data;

endmodule

// File: tb/tb_inst_fetch_arb.sv
// Directed self-checking bench for inst_fetch_arb with a small ROM model.
module tb_inst_fetch_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_req = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic        cpu_gnt;
    logic        dbg_req = 1'b0;
    logic [31:0] dbg_addr = '0;
    logic        dbg_gnt;
    logic        cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        cpu_rerr;
    logic        dbg_rvalid;
    logic [31:0] dbg_rdata;
    logic        dbg_rerr;
    logic        cpu_flush = 1'b0;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic [16:0] romIdx;

    int totalChecks = 0;
    int badChecks   = 0;

    inst_fetch_arb #(
        .ADDR_W     (32),
        .MEM_LOG2   (17),
        .STARVE_MAX (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_addr   (cpu_addr),
        .cpu_gnt    (cpu_gnt),
        .dbg_req    (dbg_req),
        .dbg_addr   (dbg_addr),
        .dbg_gnt    (dbg_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .cpu_rerr   (cpu_rerr),
        .dbg_rvalid (dbg_rvalid),
        .dbg_rdata  (dbg_rdata),
        .dbg_rerr   (dbg_rerr),
        .cpu_flush  (cpu_flush),
        .rom_ce     (rom_ce),
        .rom_addr   (rom_addr),
        .rom_inst   (rom_inst)
    );

    always #5 clk = ~clk;

    // ROM model: word 1 holds the reference instruction, every other word is C0DE_0000 | index.
    always_comb begin
        romIdx   = rom_addr[18:2];
        rom_inst = (romIdx == 17'd1) ? 32'h3401_0020 : (32'hC0DE_0000 | {15'b0, romIdx});
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalChecks++;
        if (obs !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic cr, input logic [31:0] ca,
                                 input logic dr, input logic [31:0] da, input logic fl);
        cpu_req   = cr;
        cpu_addr  = ca;
        dbg_req   = dr;
        dbg_addr  = da;
        cpu_flush = fl;
    endtask

    initial begin
        // Reset: requesting while in reset must not grant
        applyStimulus(1'b1, 32'h4, 1'b0, 32'h0, 1'b0);
        #12;
        checkOutput("rst_cpu_gnt", cpu_gnt, 0);
        checkOutput("rst_rom_ce", rom_ce, 0);
        checkOutput("rst_cpu_rvalid", cpu_rvalid, 0);
        checkOutput("rst_cpu_rdata", cpu_rdata, 0);
        checkOutput("rst_dbg_rvalid", dbg_rvalid, 0);
        checkOutput("rst_dbg_rerr", dbg_rerr, 0);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

        // Basic CPU fetch of word 1
        @(negedge clk);
        applyStimulus(1'b1, 32'h0000_0004, 1'b0, 32'h0, 1'b0);
        #1;
        checkOutput("basic_cpu_gnt", cpu_gnt, 1);
        checkOutput("basic_dbg_gnt", dbg_gnt, 0);
        checkOutput("basic_rom_ce", rom_ce, 1);
        checkOutput("basic_rom_addr", rom_addr, 32'h4);
        @(negedge clk);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        #1;
        checkOutput("basic_rvalid", cpu_rvalid, 1);
        checkOutput("basic_rdata", cpu_rdata, 32'h3401_0020);
        checkOutput("basic_rerr", cpu_rerr, 0);
        checkOutput("idle_gnt", {cpu_gnt, dbg_gnt}, 0);
        checkOutput("idle_rom_ce", rom_ce, 0);
        checkOutput("idle_rom_addr", rom_addr, 0);
        @(negedge clk);
        #1;
        checkOutput("idle_rvalid", cpu_rvalid, 0);
        checkOutput("idle_dbg_rvalid", dbg_rvalid, 0);
        checkOutput("hold_rdata", cpu_rdata, 32'h3401_0020);

        // Back-to-back CPU fetches
        @(negedge clk);
        applyStimulus(1'b1, 32'h8, 1'b0, 32'h0, 1'b0);
        #1;
        checkOutput("b2b_gnt0", cpu_gnt, 1);
        @(negedge clk);
        applyStimulus(1'b1, 32'hC, 1'b0, 32'h0, 1'b0);
        #1;
        checkOutput("b2b_gnt1", cpu_gnt, 1);
        checkOutput("b2b_rvalid0", cpu_rvalid, 1);
        checkOutput("b2b_rdata0", cpu_rdata, 32'hC0DE_0002);
        @(negedge clk);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        #1;
        checkOutput("b2b_rvalid1", cpu_rvalid, 1);
        checkOutput("b2b_rdata1", cpu_rdata, 32'hC0DE_0003);

        // Debug-only fetch
        @(negedge clk);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h10, 1'b0);
        #1;
        checkOutput("dbg_gnt", dbg_gnt, 1);
        checkOutput("dbg_rom_addr", rom_addr, 32'h10);
        @(negedge clk);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        #1;
        checkOutput("dbg_rvalid", dbg_rvalid, 1);
        checkOutput("dbg_rdata", dbg_rdata, 32'hC0DE_0004);
        checkOutput("dbg_cpu_quiet", cpu_rvalid, 0);

        // Misaligned CPU address
        @(negedge clk);
        applyStimulus(1'b1, 32'h0000_0006, 1'b0, 32'h0, 1'b0);
        #1;
        checkOutput("mis_gnt", cpu_gnt, 1);
        checkOutput("mis_rom_ce", rom_ce, 0);
        @(negedge clk);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        #1;
        checkOutput("mis_rvalid", cpu_rvalid, 1);
        checkOutput("mis_rdata", cpu_rdata, 0);
        checkOutput("mis_rerr", cpu_rerr, 1);

        // Out-of-range debug address, one word past the ROM
        @(negedge clk);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h0008_0000, 1'b0);
        #1;
        checkOutput("oor_gnt", dbg_gnt, 1);
        checkOutput("oor_rom_ce", rom_ce, 0);
        @(negedge clk);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        #1;
        checkOutput("oor_rvalid", dbg_rvalid, 1);
        checkOutput("oor_rdata", dbg_rdata, 0);
        checkOutput("oor_rerr", dbg_rerr, 1);

        // Last ROM word is still in range
        @(negedge clk);
        applyStimulus(1'b1, 32'h0007_FFFC, 1'b0, 32'h0, 1'b0);
        #1;
        checkOutput("top_rom_ce", rom_ce, 1);
        @(negedge clk);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        #1;
        checkOutput("top_rdata", cpu_rdata, 32'hC0DF_FFFF);
        checkOutput("top_rerr", cpu_rerr, 0);

        // Flush in the response cycle hides the response and keeps old rdata
        @(negedge clk);
        applyStimulus(1'b1, 32'h14, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        applyStimulus(1'b1, 32'h18, 1'b0, 32'h0, 1'b0);
        #1;
        checkOutput("pre_flush_rdata", cpu_rdata, 32'hC0DE_0005);
        @(negedge clk);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        #1;
        checkOutput("flush_rvalid", cpu_rvalid, 0);
        checkOutput("flush_rdata", cpu_rdata, 32'hC0DE_0005);
        @(negedge clk);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        #1;
        checkOutput("post_flush_rdata", cpu_rdata, 32'hC0DE_0005);

`ifndef IFETCH_RR_EN
        // Fixed priority with starvation override: C C C C D C C C C D
        @(negedge clk);
        applyStimulus(1'b1, 32'h0, 1'b1, 32'h20, 1'b0);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            checkOutput($sformatf("starve_cpu%0d", i), cpu_gnt, (i == 4 || i == 9) ? 0 : 1);
            checkOutput($sformatf("starve_dbg%0d", i), dbg_gnt, (i == 4 || i == 9) ? 1 : 0);
            if (i == 5) checkOutput("starve_dbg_rvalid", dbg_rvalid, 1);
        end
`endif

        // Reset asserted in a grant cycle
        @(negedge clk);
        applyStimulus(1'b1, 32'h4, 1'b0, 32'h0, 1'b0);
        #1;
        checkOutput("rg_gnt_before", cpu_gnt, 1);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("rg_gnt", cpu_gnt, 0);
        checkOutput("rg_rom_ce", rom_ce, 0);
        checkOutput("rg_rvalid", cpu_rvalid, 0);
        checkOutput("rg_rdata", cpu_rdata, 0);
        checkOutput("rg_dbg_rdata", dbg_rdata, 0);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        #1;
        checkOutput("rg_rvalid_rel", cpu_rvalid, 0);
        @(negedge clk);
        #1;
        checkOutput("rg_rvalid_rel2", cpu_rvalid, 0);

`ifdef IFETCH_RR_EN
        // Round-robin after reset: D C D C D C
        @(negedge clk);
        applyStimulus(1'b1, 32'h0, 1'b1, 32'h20, 1'b0);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            checkOutput($sformatf("rr_dbg%0d", i), dbg_gnt, (i % 2 == 0) ? 1 : 0);
            checkOutput($sformatf("rr_cpu%0d", i), cpu_gnt, (i % 2 == 1) ? 1 : 0);
        end
`endif

        @(negedge clk);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
